// File: rtl/blastn_pkg.sv
// Shared Blastn accelerator constants: memory word width and requester ID sizing.
// Pure declarations, no logic.
package blastn_pkg;

   localparam int MEM_W = 32;

   function automatic int sr_id_w(input int nreq);
      return $clog2(nreq);
   endfunction

endpackage

// File: rtl/seq_read_tag_fifo.sv
// In-order requester-ID FIFO; head is combinational from storage, flags and count are registered.
// Pushes while full and pops while empty are ignored, so callers may gate loosely.
module seq_read_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_nxt;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = store[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end

   // Payload needs no reset: it is only read while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (push_ok) store[wr_ptr] <= din;
   end

endmodule

// File: rtl/seq_read_mem_arb.sv
// Round-robin share of one memory port among NREQ sequence read units, zero-latency both ways.
// Issue stalls while the tag FIFO is full; each response is held until its owning unit is ready.
module seq_read_mem_arb
   import blastn_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ*MEM_W-1:0]    sr_req_msg,
   input  logic [NREQ-1:0]          sr_req_val,
   output logic [NREQ-1:0]          sr_req_rdy,
   output logic [MEM_W-1:0]         sr_resp_msg,
   output logic [NREQ-1:0]          sr_resp_val,
   input  logic [NREQ-1:0]          sr_resp_rdy,
   output logic [MEM_W-1:0]         mem_req_msg,
   output logic                     mem_req_val,
   input  logic                     mem_req_rdy,
   input  logic [MEM_W-1:0]         mem_resp_msg,
   input  logic                     mem_resp_val,
   output logic                     mem_resp_rdy,
   output logic [$clog2(DEPTH):0]   outstanding
);

   localparam int SR_ID_W = sr_id_w(NREQ);

   logic [SR_ID_W-1:0] prio_ptr;
   logic [SR_ID_W-1:0] gnt_id;
   logic               gnt_any;
   logic               issue_en;
   logic               req_hs;
   logic               resp_hs;
   logic [SR_ID_W-1:0] head;
   logic               full;
   logic               empty;

   // Walk from the farthest candidate back to prio_ptr so the nearest valid unit wins.
   always_comb begin
      gnt_id  = '0;
      gnt_any = 1'b0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (sr_req_val[(int'(prio_ptr) + k) % NREQ]) begin
            gnt_any = 1'b1;
            gnt_id  = SR_ID_W'((int'(prio_ptr) + k) % NREQ);
         end
      end
   end

   assign issue_en    = gnt_any & ~full;
   assign req_hs      = issue_en & mem_req_rdy;
   assign mem_req_val = issue_en;
   assign mem_req_msg = gnt_any ? sr_req_msg[int'(gnt_id)*MEM_W +: MEM_W] : '0;

   always_comb begin
      sr_req_rdy = '0;
      if (req_hs) sr_req_rdy = NREQ'(1) << gnt_id;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_ptr <= '0;
      end else if (req_hs) begin
         prio_ptr <= SR_ID_W'((int'(gnt_id) + 1) % NREQ);
      end
   end

   // Responses are steered by the oldest outstanding tag; memory must return in order.
   always_comb begin
      sr_resp_val  = '0;
      mem_resp_rdy = 1'b0;
      if (!empty) begin
         if (mem_resp_val) sr_resp_val = NREQ'(1) << head;
         mem_resp_rdy = sr_resp_rdy[head];
      end
   end

   assign sr_resp_msg = mem_resp_msg;
   assign resp_hs     = mem_resp_val & mem_resp_rdy;

   seq_read_tag_fifo #(
      .DEPTH (DEPTH),
      .W     (SR_ID_W)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (req_hs),
      .din   (gnt_id),
      .pop   (resp_hs),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );

endmodule

// File: tb/tb_seq_read_mem_arb.sv
// Directed bench for seq_read_mem_arb with a queue-based reference model checked every cycle.
module tb_seq_read_mem_arb;

   localparam int NREQ  = 4;
   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ*32-1:0]   sr_req_msg;
   logic [NREQ-1:0]      sr_req_val;
   logic [NREQ-1:0]      sr_req_rdy;
   logic [31:0]          sr_resp_msg;
   logic [NREQ-1:0]      sr_resp_val;
   logic [NREQ-1:0]      sr_resp_rdy;
   logic [31:0]          mem_req_msg;
   logic                 mem_req_val;
   logic                 mem_req_rdy;
   logic [31:0]          mem_resp_msg;
   logic                 mem_resp_val;
   logic                 mem_resp_rdy;
   logic [$clog2(DEPTH):0] outstanding;

   always #5 clk = ~clk;

   seq_read_mem_arb #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .sr_req_msg   (sr_req_msg),
      .sr_req_val   (sr_req_val),
      .sr_req_rdy   (sr_req_rdy),
      .sr_resp_msg  (sr_resp_msg),
      .sr_resp_val  (sr_resp_val),
      .sr_resp_rdy  (sr_resp_rdy),
      .mem_req_msg  (mem_req_msg),
      .mem_req_val  (mem_req_val),
      .mem_req_rdy  (mem_req_rdy),
      .mem_resp_msg (mem_resp_msg),
      .mem_resp_val (mem_resp_val),
      .mem_resp_rdy (mem_resp_rdy),
      .outstanding  (outstanding)
   );

   int checks = 0;
   int fails  = 0;

   // Hand-computed expectations posted by the stimulus, evaluated by the compare process.
   string       lit_name [128];
   logic [31:0] lit_act  [128];
   logic [31:0] lit_exp  [128];
   int          lit_wr = 0;
   int          lit_rd = 0;

   task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      lit_name[lit_wr] = name;
      lit_act[lit_wr]  = act;
      lit_exp[lit_wr]  = exp;
      lit_wr++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding IDs as a queue, priority pointer as an integer.
   int mq[$];
   int mptr = 0;

   initial begin : compare
      int  g, h;
      bit  issue, p_push, p_pop;
      int  p_gnt;
      logic [31:0] e_msg;
      logic [NREQ-1:0] e_req_rdy, e_resp_val;
      logic e_resp_rdy;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mq.delete();
            mptr = 0;
         end
         g = -1;
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && sr_req_val[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
         issue     = (g >= 0) && (mq.size() < DEPTH);
         e_msg     = (g >= 0) ? sr_req_msg[g*32 +: 32] : 32'h0;
         e_req_rdy = (issue && mem_req_rdy) ? NREQ'(1 << g) : '0;
         h = -1;
         e_resp_val = '0;
         e_resp_rdy = 1'b0;
         if (mq.size() > 0) begin
            h = mq[0];
            e_resp_val = mem_resp_val ? NREQ'(1 << h) : '0;
            e_resp_rdy = sr_resp_rdy[h];
         end
         chk("mem_req_val",  32'(mem_req_val),  32'(issue));
         chk("mem_req_msg",  mem_req_msg,       e_msg);
         chk("sr_req_rdy",   32'(sr_req_rdy),   32'(e_req_rdy));
         chk("sr_resp_val",  32'(sr_resp_val),  32'(e_resp_val));
         chk("mem_resp_rdy", 32'(mem_resp_rdy), 32'(e_resp_rdy));
         chk("sr_resp_msg",  sr_resp_msg,       mem_resp_msg);
         chk("outstanding",  32'(outstanding),  32'(mq.size()));
         p_push = reset && issue && mem_req_rdy;
         p_pop  = reset && (h >= 0) && mem_resp_val && e_resp_rdy;
         p_gnt  = g;
         while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
         end
         @(posedge clk);
         if (reset) begin
            if (p_pop) void'(mq.pop_front());
            if (p_push) begin
               mq.push_back(p_gnt);
               mptr = (p_gnt + 1) % NREQ;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addr_of(input int u);
      return 32'(16 * (u + 1));
   endfunction

   initial begin : stim
      int seq_g [8];
      reset        = 1'b1;
      sr_req_val   = '0;
      sr_resp_rdy  = '0;
      mem_req_rdy  = 1'b0;
      mem_resp_msg = '0;
      mem_resp_val = 1'b0;
      for (int i = 0; i < NREQ; i++) sr_req_msg[i*32 +: 32] = addr_of(i);
      #1 reset = 1'b0;
      tick();
      tick();
      #1;
      expect_lit("rst_mem_req_val",  32'(mem_req_val),  32'h0);
      expect_lit("rst_mem_resp_rdy", 32'(mem_resp_rdy), 32'h0);
      expect_lit("rst_sr_req_rdy",   32'(sr_req_rdy),   32'h0);
      expect_lit("rst_sr_resp_val",  32'(sr_resp_val),  32'h0);
      expect_lit("rst_outstanding",  32'(outstanding),  32'h0);
      expect_lit("rst_mem_req_msg",  mem_req_msg,       32'h0);
      tick();
      reset = 1'b1;
      tick();

      // Fill: all units valid, grants 0,1,2,3 then blocked by full FIFO.
      sr_req_val  = 4'hF;
      mem_req_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         expect_lit("fill_rdy", 32'(sr_req_rdy), 32'(1 << c));
         expect_lit("fill_msg", mem_req_msg,     addr_of(c));
         tick();
      end
      #1;
      expect_lit("full_rdy",  32'(sr_req_rdy),  32'h0);
      expect_lit("full_val",  32'(mem_req_val), 32'h0);
      expect_lit("full_outs", 32'(outstanding), 32'h4);
      sr_req_val  = '0;
      mem_req_rdy = 1'b0;
      tick();

      // Drain: responses A0..A3 routed to 0..3, unit 2 stalls two cycles.
      sr_resp_rdy  = 4'hF;
      mem_resp_val = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mem_resp_msg = 32'hA0 + 32'(k);
         if (k == 2) begin
            sr_resp_rdy = 4'b1011;
            repeat (2) begin
               #1;
               expect_lit("stall_mem_resp_rdy", 32'(mem_resp_rdy), 32'h0);
               expect_lit("stall_sr_resp_val",  32'(sr_resp_val),  32'h4);
               tick();
            end
            sr_resp_rdy = 4'hF;
         end
         #1;
         expect_lit("drain_val", 32'(sr_resp_val),  32'(1 << k));
         expect_lit("drain_msg", sr_resp_msg,       32'hA0 + 32'(k));
         expect_lit("drain_rdy", 32'(mem_resp_rdy), 32'h1);
         tick();
      end
      mem_resp_val = 1'b0;
      #1;
      expect_lit("drain_outs", 32'(outstanding), 32'h0);
      tick();

      // Single requester: unit 2, address 0x100, response one cycle later.
      sr_req_msg[2*32 +: 32] = 32'h100;
      sr_req_val  = 4'b0100;
      mem_req_rdy = 1'b1;
      #1;
      expect_lit("single_msg", mem_req_msg,     32'h100);
      expect_lit("single_rdy", 32'(sr_req_rdy), 32'h4);
      tick();
      sr_req_val   = '0;
      mem_resp_msg = 32'hDEADBEEF;
      mem_resp_val = 1'b1;
      #1;
      expect_lit("single_outs1", 32'(outstanding), 32'h1);
      expect_lit("single_rval",  32'(sr_resp_val), 32'h4);
      expect_lit("single_rmsg",  sr_resp_msg,      32'hDEADBEEF);
      tick();
      mem_resp_val = 1'b0;
      #1;
      expect_lit("single_outs0", 32'(outstanding), 32'h0);
      sr_req_msg[2*32 +: 32] = addr_of(2);

      // Stray response with empty FIFO is refused.
      mem_resp_val = 1'b1;
      mem_resp_msg = 32'h55;
      #1;
      expect_lit("stray_rdy", 32'(mem_resp_rdy), 32'h0);
      expect_lit("stray_val", 32'(sr_resp_val),  32'h0);
      tick();
      mem_resp_val = 1'b0;
      #1;
      expect_lit("stray_outs", 32'(outstanding), 32'h0);

      // Three issues from unit 1, then reset mid-operation.
      sr_req_val  = 4'b0010;
      mem_req_rdy = 1'b1;
      repeat (3) begin
         #1;
         expect_lit("solo_rdy", 32'(sr_req_rdy), 32'h2);
         tick();
      end
      sr_req_val   = '0;
      mem_req_rdy  = 1'b0;
      mem_resp_val = 1'b1;
      #1;
      expect_lit("pre_rst_outs", 32'(outstanding),  32'h3);
      expect_lit("pre_rst_rdy",  32'(mem_resp_rdy), 32'h1);
      reset = 1'b0;
      #1;
      expect_lit("mid_rst_outs", 32'(outstanding),  32'h0);
      expect_lit("mid_rst_rdy",  32'(mem_resp_rdy), 32'h0);
      expect_lit("mid_rst_val",  32'(sr_resp_val),  32'h0);
      tick();
      tick();
      reset = 1'b1;

      // Fairness: units 0 and 3, memory ready toggles; first grant after reset is unit 0.
      seq_g = '{0, 3, 3, 0, 0, 3, 3, 0};
      sr_req_val  = 4'b1001;
      sr_resp_rdy = 4'hF;
      for (int c = 0; c < 8; c++) begin
         mem_req_rdy = (c % 2 == 0);
         #1;
         expect_lit("fair_msg", mem_req_msg, addr_of(seq_g[c]));
         expect_lit("fair_rdy", 32'(sr_req_rdy), (c % 2 == 0) ? 32'(1 << seq_g[c]) : 32'h0);
         tick();
      end
      sr_req_val   = '0;
      mem_req_rdy  = 1'b0;
      mem_resp_val = 1'b0;
      tick();
      tick();
      for (int w = 0; w < 20 && lit_rd < lit_wr; w++) tick();
      if (lit_rd < lit_wr) $display("FAIL lit_drain: got %0d pending, expected 0", lit_wr - lit_rd);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seq_read_mem_arb.md
# seq_read_mem_arb

Round-robin arbiter sharing one 32-bit memory request/response port among NREQ sequence read units (project_SeqRead_v2 instances) in the Blastn accelerator. It sits between the read units' `sr_req_*`/`sr_resp_*` ports and the single database memory port. It records the requester ID of every issued request in an in-order tag FIFO and steers each memory response back to the unit that issued it.

## Interface
- NREQ, 4: number of sequence read units, 2..8.
- DEPTH, 4: maximum outstanding memory requests (tag FIFO entries), power of 2, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); one clock; reset is asynchronous and active-low.
- sr_req_msg  in  NREQ*32  per-unit request address; unit i occupies bits [32i+31:32i].
- sr_req_val  in  NREQ  per-unit request valid.
- sr_req_rdy  out  NREQ  per-unit request ready; one-hot or zero.
- sr_resp_msg  out  32  response data, broadcast to all units.
- sr_resp_val  out  NREQ  per-unit response valid; one-hot or zero.
- sr_resp_rdy  in  NREQ  per-unit response ready.
- mem_req_msg  out  32  address to memory.
- mem_req_val  out  1  memory request valid.
- mem_req_rdy  in  1  memory request ready.
- mem_resp_msg  in  32  memory response data.
- mem_resp_val  in  1  memory response valid.
- mem_resp_rdy  out  1  memory response ready.
- outstanding  out  $clog2(DEPTH)+1  number of issued requests without a returned response.

## Operation
- Grant: the first requester with `sr_req_val` set, searched circularly starting at `prio_ptr`. `gnt` is one-hot or zero.
- Issue enabled when any `sr_req_val` is set and the tag FIFO is not full.
- When issue is enabled: `mem_req_val=1`, `mem_req_msg` = granted unit's message, and `sr_req_rdy[gnt]` = `mem_req_rdy`. All other rdy bits are 0.
- When issue is not enabled, all `sr_req_rdy` bits and `mem_req_val` are 0.
- Request handshake (`mem_req_val & mem_req_rdy`):
  - push the granted ID into the tag FIFO;
  - `prio_ptr` ← (gnt+1) mod NREQ.
- `prio_ptr` holds its value when no handshake occurs.
- Response routing: when the FIFO is non-empty, head ID h gives:
  - `sr_resp_val[h]` = `mem_resp_val`;
  - `mem_resp_rdy` = `sr_resp_rdy[h]`;
  - `sr_resp_msg` = `mem_resp_msg`.
- Response handshake pops the FIFO.
- FIFO empty: `mem_resp_rdy=0` and all `sr_resp_val=0`. A stray memory response is not accepted.
- FIFO full: no issue, even if a pop occurs in the same cycle. Full is registered state; there is no full-pass-through.
- Simultaneous push and pop when not full or empty: `outstanding` is unchanged and both pointers advance.
- Pointer arithmetic is modulo DEPTH. `outstanding` ranges 0..DEPTH and never wraps.
- Responses return in issue order; the memory must be in-order.

## Timing
- Request and response paths are combinational: zero added latency and zero bubbles. Back-to-back issue every cycle is allowed until the FIFO is full.
- `sr_req_msg` → `mem_req_msg` is a pure mux. Grant depends only on `sr_req_val` and registered state, never on `mem_req_rdy`.
- Reset values:
  - `prio_ptr=0`, FIFO empty, `outstanding=0`;
  - hence `mem_req_val=0`, `mem_resp_rdy=0`, `sr_resp_val=0`, `sr_req_rdy=0`.
  - `sr_resp_msg` follows `mem_resp_msg`, and `mem_req_msg` is 0 when no unit is valid.
- Reset mid-operation: all tags are discarded immediately and asynchronously. The memory and the read units must be reset in the same window; in-flight responses are not tracked.
- With a single active unit, that unit is granted every cycle. With multiple active units, no unit waits more than NREQ-1 grants.

## Structure
- Shared package `blastn_pkg`: memory address/data width constant (32) and `SR_ID_W = $clog2(NREQ)`.
- Sub-module `seq_read_tag_fifo`:
  - parameters DEPTH and width `SR_ID_W`;
  - ports: push/pop, `head`, `full`, `empty`, `count`;
  - async active-low reset, registered full/empty flags.
- The round-robin grant logic is inline in `seq_read_mem_arb`.

## Test plan
- Single requester: unit 2 requests addr 0x100, memory responds 0xDEADBEEF one cycle later → `mem_req_msg=0x100`, `sr_resp_val=4'b0100`, `sr_resp_msg=0xDEADBEEF`, `outstanding` goes 1 then 0.
- All four units hold val with `mem_req_rdy=1` and DEPTH=4 → grants issue in order 0,1,2,3. In the fifth cycle `sr_req_rdy=0` because the FIFO is full and `outstanding=4`.
- Responses for the previous scenario (0xA0..0xA3) arrive → delivered to units 0,1,2,3 in order. A unit with `sr_resp_rdy=0` stalls `mem_resp_rdy` for exactly those cycles.
- `mem_resp_val=1` with FIFO empty → `mem_resp_rdy=0`, no `sr_resp_val` asserted.
- Fairness: units 0 and 3 always valid, `mem_req_rdy` toggling each cycle → grants alternate 0,3,0,3, and `prio_ptr` is unchanged in stall cycles.
- Assert `reset=0` with 3 requests outstanding → `outstanding=0` and `mem_resp_rdy=0` within the same cycle. After release, the first grant goes to unit 0.
